// File: rtl/execute_pipe.sv
// execute_pipe: registered EX stage. Operand-B select, extended ALU with
// signed/unsigned compares and shifts, iterative shift-add multiply, destination
// select, and a valid/ready output register.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | accepting ops; single-cycle results load the output register
// MUL    | shift-add multiply running, one iteration per cycle
module execute_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_fun,
  input  logic [DATA_W-1:0]     input_A,
  input  logic [DATA_W-1:0]     input_sz,
  input  logic [DATA_W-1:0]     input_register,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  sel_alu,
  input  logic                  sel_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_ALU,
  output logic [DATA_W-1:0]     out_dato_registro,
  output logic [REG_ADDR_W-1:0] out_mux_sel_reg,
  output logic                  out_zero,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  localparam int MSB = DATA_W - 1;
  // Counter starts one below DATA_W; the iteration at count zero is the last.
  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(DATA_W - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       mcand_q, mplier_q, acc_q;
  logic [SHAMT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]       pend_dato_q;
  logic [REG_ADDR_W-1:0]   pend_dest_q;
  logic                    out_valid_q;
  logic [DATA_W-1:0]       out_alu_q, out_dato_q;
  logic [REG_ADDR_W-1:0]   out_dest_q;
  logic                    out_ovf_q;

  logic [DATA_W-1:0]       b_op, sum, diff, alu_res, acc_step;
  logic [SHAMT_W-1:0]      shamt;
  logic                    alu_ovf;
  logic                    out_free, accept, is_mul, mul_last, mul_done;

  // Combinational ALU on the incoming operands
  always_comb begin
    b_op    = sel_alu ? input_sz : input_register;
    sum     = input_A + b_op;
    diff    = input_A - b_op;
    shamt   = b_op[SHAMT_W-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_fun)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (input_A[MSB] == b_op[MSB]) && (sum[MSB] != input_A[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (input_A[MSB] != b_op[MSB]) && (diff[MSB] != input_A[MSB]);
      end
      OP_AND:  alu_res = input_A & b_op;
      OP_OR:   alu_res = input_A | b_op;
      OP_NOR:  alu_res = ~(input_A | b_op);
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(input_A) < $signed(b_op))};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (input_A < b_op)};
      OP_SLL:  alu_res = input_A << shamt;
      OP_SRL:  alu_res = input_A >> shamt;
      OP_SRA:  alu_res = $signed(input_A) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Handshake and multiply progress terms
  always_comb begin
    out_free = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
    is_mul   = (alu_fun == OP_MUL);
    mul_last = (cnt_q == '0);
    mul_done = (state_q == S_MUL) && mul_last && out_free;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (mul_done)         state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == S_IDLE) && out_free;
    busy     = (state_q == S_MUL);
  end

  // Multiplier datapath: latch on accept, one shift-add per cycle until the last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      pend_dato_q <= '0;
      pend_dest_q <= '0;
    end else if (accept && is_mul) begin
      mcand_q     <= input_A;
      mplier_q    <= b_op;
      acc_q       <= '0;
      cnt_q       <= CNT_LAST;
      pend_dato_q <= input_register;
      pend_dest_q <= sel_reg ? rd : rt;
    end else if ((state_q == S_MUL) && !mul_last) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  // Output register: load single-cycle result or finished product, else drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_alu_q   <= '0;
      out_dato_q  <= '0;
      out_dest_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid_q <= 1'b1;
      out_alu_q   <= alu_res;
      out_dato_q  <= input_register;
      out_dest_q  <= sel_reg ? rd : rt;
      out_ovf_q   <= alu_ovf;
    end else if (mul_done) begin
      out_valid_q <= 1'b1;
      out_alu_q   <= acc_step;
      out_dato_q  <= pend_dato_q;
      out_dest_q  <= pend_dest_q;
      out_ovf_q   <= 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_ALU           = out_alu_q;
  assign out_dato_registro = out_dato_q;
  assign out_mux_sel_reg   = out_dest_q;
  assign out_ovf           = out_ovf_q;
  assign out_zero          = (out_alu_q == '0);

endmodule
